// File: rtl/uv_exu_rsb.sv
// rtl/uv_exu_rsb.sv - execute-stage result buffer: 2-entry skid, branch resolve, writeback handshake
// Optional macro UV_EXU_RSB_FWD_EN adds fwd0_*/fwd1_* bypass ports from the main/skid entries.
module uv_exu_rsb #(
    parameter int ALU_DW = 32,
    parameter int RID_W  = 5,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [ALU_DW-1:0] in_res,
    input  logic              in_cmp_eq,
    input  logic              in_cmp_ne,
    input  logic              in_cmp_lt,
    input  logic              in_cmp_ge,
    input  logic [2:0]        in_br_typ,
    input  logic [PC_W-1:0]   in_br_tgt,
    input  logic              in_rd_wr,
    input  logic [RID_W-1:0]  in_rd_idx,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [ALU_DW-1:0] out_res,
    output logic              out_rd_wr,
    output logic [RID_W-1:0]  out_rd_idx,
    output logic              br_red,
    output logic [PC_W-1:0]   br_pc
`ifdef UV_EXU_RSB_FWD_EN
    ,
    output logic              fwd0_vld,
    output logic [RID_W-1:0]  fwd0_idx,
    output logic [ALU_DW-1:0] fwd0_res,
    output logic              fwd1_vld,
    output logic [RID_W-1:0]  fwd1_idx,
    output logic [ALU_DW-1:0] fwd1_res
`endif
);

    logic              m_vld_q, m_vld_d, s_vld_q, s_vld_d;
    logic [ALU_DW-1:0] m_res_q, m_res_d, s_res_q, s_res_d;
    logic              m_rd_wr_q, m_rd_wr_d, s_rd_wr_q, s_rd_wr_d;
    logic [RID_W-1:0]  m_rd_idx_q, m_rd_idx_d, s_rd_idx_q, s_rd_idx_d;
    logic              in_rdy_q, in_rdy_d;
    logic              br_red_q, br_red_d;
    logic [PC_W-1:0]   br_pc_q, br_pc_d;
    logic              acc, pop, taken;

    assign acc = in_vld & in_rdy_q;
    assign pop = m_vld_q & out_rdy;
    assign taken = ((in_br_typ == 3'd1) & in_cmp_eq) | ((in_br_typ == 3'd2) & in_cmp_ne) |
                   ((in_br_typ == 3'd3) & in_cmp_lt) | ((in_br_typ == 3'd4) & in_cmp_ge);

    always_comb begin
        m_vld_d    = m_vld_q;
        m_res_d    = m_res_q;
        m_rd_wr_d  = m_rd_wr_q;
        m_rd_idx_d = m_rd_idx_q;
        s_vld_d    = s_vld_q;
        s_res_d    = s_res_q;
        s_rd_wr_d  = s_rd_wr_q;
        s_rd_idx_d = s_rd_idx_q;
        br_red_d   = 1'b0;
        br_pc_d    = br_pc_q;
        if (flush) begin
            m_vld_d = 1'b0;
            s_vld_d = 1'b0;
        end else begin
            // Retire M first; an entry waiting in S slides forward.
            if (pop) begin
                if (s_vld_q) begin
                    m_res_d    = s_res_q;
                    m_rd_wr_d  = s_rd_wr_q;
                    m_rd_idx_d = s_rd_idx_q;
                    s_vld_d    = 1'b0;
                end else begin
                    m_vld_d = 1'b0;
                end
            end
            // New result lands in M if it is free after the pop, else in S.
            if (acc) begin
                if (!m_vld_d) begin
                    m_vld_d    = 1'b1;
                    m_res_d    = in_res;
                    m_rd_wr_d  = in_rd_wr;
                    m_rd_idx_d = in_rd_idx;
                end else begin
                    s_vld_d    = 1'b1;
                    s_res_d    = in_res;
                    s_rd_wr_d  = in_rd_wr;
                    s_rd_idx_d = in_rd_idx;
                end
                br_red_d = taken;
                if (taken) br_pc_d = in_br_tgt;
            end
        end
        in_rdy_d = ~s_vld_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_vld_q    <= 1'b0;
            m_res_q    <= '0;
            m_rd_wr_q  <= 1'b0;
            m_rd_idx_q <= '0;
            s_vld_q    <= 1'b0;
            s_res_q    <= '0;
            s_rd_wr_q  <= 1'b0;
            s_rd_idx_q <= '0;
            in_rdy_q   <= 1'b1;
            br_red_q   <= 1'b0;
            br_pc_q    <= '0;
        end else begin
            m_vld_q    <= m_vld_d;
            m_res_q    <= m_res_d;
            m_rd_wr_q  <= m_rd_wr_d;
            m_rd_idx_q <= m_rd_idx_d;
            s_vld_q    <= s_vld_d;
            s_res_q    <= s_res_d;
            s_rd_wr_q  <= s_rd_wr_d;
            s_rd_idx_q <= s_rd_idx_d;
            in_rdy_q   <= in_rdy_d;
            br_red_q   <= br_red_d;
            br_pc_q    <= br_pc_d;
        end
    end

    assign in_rdy     = in_rdy_q;
    assign out_vld    = m_vld_q;
    assign out_res    = m_res_q;
    assign out_rd_wr  = m_rd_wr_q & (m_rd_idx_q != '0);
    assign out_rd_idx = m_rd_idx_q;
    assign br_red     = br_red_q;
    assign br_pc      = br_pc_q;

`ifdef UV_EXU_RSB_FWD_EN
    assign fwd0_vld = m_vld_q & m_rd_wr_q & (m_rd_idx_q != '0);
    assign fwd0_idx = m_rd_idx_q;
    assign fwd0_res = m_res_q;
    assign fwd1_vld = s_vld_q & s_rd_wr_q & (s_rd_idx_q != '0);
    assign fwd1_idx = s_rd_idx_q;
    assign fwd1_res = s_res_q;
`endif

endmodule

// File: doc/uv_exu_rsb.md
Name: uv_exu_rsb

Overview:
- Execute-stage result buffer directly downstream of the ALU.
- Captures the ALU result, compare flags and destination info from the execute stage. Resolves conditional branches from the compare flags. Presents results to the writeback stage over a valid/ready handshake.
- 2-entry skid buffer: the upstream ready is a register output, so the ALU stall path has no combinational dependence on writeback ready.

Parameters:
- ALU_DW, 32, ALU data width; result width.
- RID_W, 5, destination register index width.
- PC_W, 32, branch target width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  pipeline flush; kills all buffered entries.
- in_vld  in  1  execute-stage result valid.
- in_rdy  out  1  buffer can accept; registered.
- in_res  in  ALU_DW  ALU result.
- in_cmp_eq  in  1  compare equal.
- in_cmp_ne  in  1  compare not equal.
- in_cmp_lt  in  1  compare less-than (signedness already applied upstream).
- in_cmp_ge  in  1  compare greater-or-equal.
- in_br_typ  in  3  0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE; 5-7 treated as none.
- in_br_tgt  in  PC_W  precomputed branch target.
- in_rd_wr  in  1  writes destination register.
- in_rd_idx  in  RID_W  destination register index.
- out_vld  out  1  result valid to writeback.
- out_rdy  in  1  writeback accepts.
- out_res  out  ALU_DW  buffered result.
- out_rd_wr  out  1  write enable; forced 0 when out_rd_idx==0.
- out_rd_idx  out  RID_W  destination index.
- br_red  out  1  one-cycle branch redirect pulse.
- br_pc  out  PC_W  redirect target; valid when br_red=1.

Behaviour:
- Reset values: in_rdy=1, out_vld=0, br_red=0. out_res, out_rd_wr, out_rd_idx, br_pc all 0.
- State: main entry M (drives out_*) and skid entry S. Each has a valid bit plus a payload of res, rd_wr, rd_idx.
- acc = in_vld & in_rdy.
- pop = out_vld & out_rdy.
- in_rdy = ~S.vld (registered).
- Occupancy states: EMPTY (M=0,S=0), ONE (M=1,S=0), FULL (M=1,S=1). S.vld=1 with M.vld=0 never occurs.
- Transitions:
  - EMPTY: acc -> ONE.
  - ONE: acc&~pop -> FULL (input to S). acc&pop -> ONE (input to M). ~acc&pop -> EMPTY.
  - FULL: pop -> ONE (S moves to M); no accept possible.
- Latency: accepted input appears on out_* the next cycle when EMPTY, or in ONE with a simultaneous pop. Order is strictly FIFO.
- Payload registers update only on load; they hold their value when the entry is invalid.
- Branch resolution on acc:
  - taken = (typ1&eq) | (typ2&ne) | (typ3&lt) | (typ4&ge).
  - If taken: next cycle br_red=1 and br_pc=in_br_tgt, independent of out_rdy.
  - Otherwise br_red=0 next cycle.
  - br_red is never asserted two cycles for one accept.
- Branch entries still occupy the buffer (link result/writeback), subject to in_rd_wr.
- flush:
  - Synchronous. Next cycle M.vld=S.vld=0, in_rdy=1, br_red=0.
  - A same-cycle acc is discarded; flush has priority.
  - A same-cycle pop still completes; writeback already sampled it.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). A pending redirect is dropped.
- out_rd_wr = M.rd_wr & (M.rd_idx != 0).

Optional Feature:
- Macro UV_EXU_RSB_FWD_EN.
- Defined: extra output ports are added:
  - fwd0_vld (1), fwd0_idx (RID_W), fwd0_res (ALU_DW) from M.
  - fwd1_vld, fwd1_idx, fwd1_res from S.
  - fwdN_vld = entry valid & rd_wr & idx!=0.
  - The issue stage uses these for bypass and prefers fwd1 (younger) on an index match.
- Undefined: the ports are absent and no forwarding logic is generated. Core behaviour is identical.

Test Plan:
- Reset with rst=1 then release; in_vld=0 -> in_rdy=1, out_vld=0, br_red=0, out_res=0.
- Stream 4 results (res 0x11..0x44, rd 1..4) with out_rdy=1 -> each appears 1 cycle later in order; in_rdy stays 1.
- out_rdy=0, push 0xA, 0xB -> FULL, in_rdy=0. Raise out_rdy -> 0xA then 0xB emitted; in_rdy=1 one cycle after 0xA pops.
- Accept BLT with cmp_lt=1, br_tgt=0x80000100 while out_rdy=0 -> br_red=1, br_pc=0x80000100 for exactly one cycle. Repeat with typ=BGE, cmp_ge=0 -> br_red stays 0.
- FULL state, then flush=1 with in_vld=1 -> next cycle out_vld=0, in_rdy=1; the flushed inputs never appear on out_*.
- rd_idx=0, rd_wr=1, res=0xFFFFFFFF -> out_vld=1, out_rd_wr=0. With UV_EXU_RSB_FWD_EN defined, fwd0_vld=0 for this entry.
